// File: rtl/opn_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : opn_seq_pkg
// Brief    : Shared state encoding and OPN register constants for the write sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package opn_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_A_SETUP   = 4'd1,
    ST_A_WR      = 4'd2,
    ST_A_HOLD    = 4'd3,
    ST_D_SETUP   = 4'd4,
    ST_D_WR      = 4'd5,
    ST_D_HOLD    = 4'd6,
    ST_GAP       = 4'd7,
    ST_BUSY_WAIT = 4'd8
  } seq_state_t;

  localparam logic [7:0] c_KON     = 8'h28;
  localparam logic [7:0] c_MODE    = 8'h27;
  localparam logic [7:0] c_DTMUL   = 8'h30;
  localparam logic [7:0] c_TL      = 8'h40;
  localparam logic [7:0] c_KSAR    = 8'h50;
  localparam logic [7:0] c_DR      = 8'h60;
  localparam logic [7:0] c_SR      = 8'h70;
  localparam logic [7:0] c_SLRR    = 8'h80;
  localparam logic [7:0] c_SSGEG   = 8'h90;
  localparam logic [7:0] c_FNUM_LO = 8'hA0;
  localparam logic [7:0] c_FNUM_HI = 8'hA4;
  localparam logic [7:0] c_FBCN    = 8'hB0;

  localparam int c_BUSY_BIT = 7;

endpackage

`default_nettype wire

// File: rtl/opn_phase_timer.sv
//------------------------------------------------------------------------------
// Module   : opn_phase_timer
// Brief    : Loadable 16-bit cen-gated down-counter; o_last marks the final count.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module opn_phase_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cen,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  output logic        o_last
);

  logic [15:0] r_cnt;

  // A load always wins so the next phase starts with a full count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 16'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_cen && (r_cnt != 16'd0)) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign o_last = (r_cnt == 16'd1);

endmodule

`default_nettype wire

// File: rtl/opn_write_sequencer.sv
//------------------------------------------------------------------------------
// Module   : opn_write_sequencer
// Brief    : Turns (register, value) commands into two-phase OPN bus write cycles.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module opn_write_sequencer
  import opn_seq_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned WR_CYC       = 1,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned GAP_CYC      = 32,
  parameter int unsigned BUSY_POLL    = 0,
  parameter int unsigned BUSY_TIMEOUT = 1024
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       cen,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic [7:0] fm_dout,
  output logic [7:0] fm_din,
  output logic       fm_addr,
  output logic       fm_cs_n,
  output logic       fm_wr_n,
  output logic       seq_busy,
  output logic       wr_done,
  output logic       busy_err
);

  seq_state_t  r_state;
  logic [7:0]  r_val;
  logic [7:0]  r_din;
  logic        r_addr;
  logic        r_cs_n;
  logic        r_wr_n;
  logic        r_done;
  logic        r_err;

  logic        w_last;
  logic        w_step;
  logic        w_load;
  logic [15:0] w_load_val;
  logic        w_fm_busy;
  logic        w_unused_dout;

  assign w_fm_busy     = fm_dout[c_BUSY_BIT];
  assign w_unused_dout = ^fm_dout[6:0];
  assign w_step        = cen && w_last;

  // Reload the timer with the duration of whichever state comes next.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = 16'(SETUP_CYC);
    case (r_state)
      ST_IDLE: w_load = cmd_valid;
      ST_A_SETUP, ST_D_SETUP: begin
        w_load     = w_step;
        w_load_val = 16'(WR_CYC);
      end
      ST_A_WR, ST_D_WR: begin
        w_load     = w_step;
        w_load_val = 16'(HOLD_CYC);
      end
      ST_A_HOLD: w_load = w_step;
      ST_D_HOLD: begin
        w_load     = w_step;
        w_load_val = (BUSY_POLL != 0) ? 16'(BUSY_TIMEOUT) : 16'(GAP_CYC);
      end
      default: ;
    endcase
  end

  opn_phase_timer u_timer (
    .clk        (clk_in),
    .rst        (rst),
    .i_cen      (cen),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_last     (w_last)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_val   <= 8'h00;
      r_din   <= 8'h00;
      r_addr  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_val   <= cmd_data;
            r_din   <= cmd_addr;
            r_addr  <= 1'b0;
            r_cs_n  <= 1'b0;
            r_state <= ST_A_SETUP;
          end
        end
        ST_A_SETUP: if (w_step) begin r_wr_n <= 1'b0; r_state <= ST_A_WR; end
        ST_A_WR:    if (w_step) begin r_wr_n <= 1'b1; r_state <= ST_A_HOLD; end
        ST_A_HOLD: begin
          if (w_step) begin
            r_addr  <= 1'b1;
            r_din   <= r_val;
            r_state <= ST_D_SETUP;
          end
        end
        ST_D_SETUP: if (w_step) begin r_wr_n <= 1'b0; r_state <= ST_D_WR; end
        ST_D_WR:    if (w_step) begin r_wr_n <= 1'b1; r_state <= ST_D_HOLD; end
        ST_D_HOLD: begin
          if (w_step) begin
            r_cs_n <= 1'b1;
            if (BUSY_POLL != 0) begin
              r_state <= ST_BUSY_WAIT;
            end else if (GAP_CYC == 0) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: if (w_step) begin r_done <= 1'b1; r_state <= ST_IDLE; end
        ST_BUSY_WAIT: begin
          if (cen) begin
            if (!w_fm_busy) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else if (w_last) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE) && !rst;
  assign seq_busy  = (r_state != ST_IDLE);
  assign fm_din    = r_din;
  assign fm_addr   = r_addr;
  assign fm_cs_n   = r_cs_n;
  assign fm_wr_n   = r_wr_n;
  assign wr_done   = r_done;
  assign busy_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_opn_write_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_opn_write_sequencer
// Brief    : Self-checking bench for opn_write_sequencer against a timeline model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_opn_write_sequencer;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic       rst;
  logic       cen[3], cmd_valid[3], cmd_ready[3];
  logic       fm_addr[3], fm_cs_n[3], fm_wr_n[3];
  logic       seq_busy[3], wr_done[3], busy_err[3];
  logic [7:0] cmd_addr[3], cmd_data[3], fm_dout[3], fm_din[3];

  int checks = 0;
  int errors = 0;

  // Default instance.
  opn_write_sequencer u_dflt (
    .clk_in(clk_in), .rst(rst), .cen(cen[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]), .fm_dout(fm_dout[0]), .fm_din(fm_din[0]),
    .fm_addr(fm_addr[0]), .fm_cs_n(fm_cs_n[0]), .fm_wr_n(fm_wr_n[0]), .seq_busy(seq_busy[0]),
    .wr_done(wr_done[0]), .busy_err(busy_err[0]));

  opn_write_sequencer #(.BUSY_POLL(1), .BUSY_TIMEOUT(16)) u_poll (
    .clk_in(clk_in), .rst(rst), .cen(cen[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]), .fm_dout(fm_dout[1]), .fm_din(fm_din[1]),
    .fm_addr(fm_addr[1]), .fm_cs_n(fm_cs_n[1]), .fm_wr_n(fm_wr_n[1]), .seq_busy(seq_busy[1]),
    .wr_done(wr_done[1]), .busy_err(busy_err[1]));

  opn_write_sequencer #(.SETUP_CYC(2), .WR_CYC(3), .HOLD_CYC(2), .GAP_CYC(0)) u_fast (
    .clk_in(clk_in), .rst(rst), .cen(cen[2]), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_addr(cmd_addr[2]), .cmd_data(cmd_data[2]), .fm_dout(fm_dout[2]), .fm_din(fm_din[2]),
    .fm_addr(fm_addr[2]), .fm_cs_n(fm_cs_n[2]), .fm_wr_n(fm_wr_n[2]), .seq_busy(seq_busy[2]),
    .wr_done(wr_done[2]), .busy_err(busy_err[2]));

  typedef struct packed {
    logic       busy;
    logic       cs_n;
    logic       wr_n;
    logic       addr;
    logic [7:0] din;
    logic       done;
  } bus_t;

  bit   cen_plan [0:1023];
  bus_t exp_q[$];

  // Expected per-cycle bus view after an acceptance at cycle 0; entry k is cycle k+1.
  // Phases: A setup/wr/hold, D setup/wr/hold, gap; each ends after its count of cen-high cycles.
  function automatic void build_timeline(input logic [7:0] ra, input logic [7:0] rd,
                                         input int s, input int w, input int h, input int g);
    int   durs[7];
    int   p;
    int   cnt;
    bus_t e;
    durs = '{s, w, h, s, w, h, g};
    exp_q.delete();
    p = 1;
    for (int ph = 0; ph < 7; ph++) begin
      cnt = 0;
      while (cnt < durs[ph] && p < 1000) begin
        e.busy = 1'b1;
        e.cs_n = (ph == 6);
        e.wr_n = !(ph == 1 || ph == 4);
        e.addr = (ph >= 3 && ph < 6);
        e.din  = (ph < 3) ? ra : ((ph < 6) ? rd : 8'h00);
        e.done = 1'b0;
        exp_q.push_back(e);
        if (cen_plan[p]) cnt++;
        p++;
      end
    end
    e = '{busy: 1'b0, cs_n: 1'b1, wr_n: 1'b1, addr: 1'b0, din: 8'h00, done: 1'b1};
    exp_q.push_back(e);
  endfunction

  // Data lines are only meaningful while chip select is active.
  function automatic bus_t observe(input int u);
    bus_t b;
    b.busy = seq_busy[u];
    b.cs_n = fm_cs_n[u];
    b.wr_n = fm_wr_n[u];
    b.done = wr_done[u];
    b.addr = (fm_cs_n[u] === 1'b0) ? fm_addr[u] : 1'b0;
    b.din  = (fm_cs_n[u] === 1'b0) ? fm_din[u] : 8'h00;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid[0] = 1'b1;
    cmd_addr[0] = 8'h27;
    cmd_data[0] = 8'h3B;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fm_cs_n[0] !== 1'b1 || fm_wr_n[0] !== 1'b1 || fm_din[0] !== 8'h00 || fm_addr[0] !== 1'b0 ||
          cmd_ready[0] !== 1'b0 || seq_busy[0] !== 1'b0 || wr_done[0] !== 1'b0 || busy_err[0] !== 1'b0)
        begin
        errors++;
        $display("FAIL reset_hold cyc%0d: cs=%b wr=%b din=%h a=%b rdy=%b busy=%b done=%b err=%b, expected 1 1 00 0 0 0 0 0",
                 i, fm_cs_n[0], fm_wr_n[0], fm_din[0], fm_addr[0], cmd_ready[0], seq_busy[0], wr_done[0], busy_err[0]);
      end
    end
    rst = 1'b0;
    cmd_valid[0] = 1'b0;
    tick();
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (cmd_ready[u] !== 1'b1 || fm_cs_n[u] !== 1'b1 || seq_busy[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release u%0d: rdy=%b cs=%b busy=%b, expected 1 1 0", u, cmd_ready[u], fm_cs_n[u], seq_busy[u]);
      end
    end
  endtask

  task automatic test_single_write();
    bus_t got;
    for (int i = 0; i < 1024; i++) cen_plan[i] = 1'b1;
    build_timeline(8'h27, 8'h3B, 1, 1, 1, 32);
    cen[0] = 1'b1;
    cmd_addr[0] = 8'h27;
    cmd_data[0] = 8'h3B;
    cmd_valid[0] = 1'b1;
    checks++;
    if (cmd_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: ready=%b expected 1", cmd_ready[0]);
    end
    tick();
    cmd_valid[0] = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = observe(0);
      checks++;
      if (got !== exp_q[k] || cmd_ready[0] !== exp_q[k].done) begin
        errors++;
        $display("FAIL single_wave cyc%0d: got %h rdy=%b, expected %h", k + 1, got, cmd_ready[0], exp_q[k]);
      end
      tick();
    end
    checks++;
    if (wr_done[0] !== 1'b0 || fm_cs_n[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_after: done=%b cs=%b, expected 0 1", wr_done[0], fm_cs_n[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seen[$];
    int second = -1;
    int dones = 0;
    int gap_wr = 0;
    cen[0] = 1'b1;
    cmd_addr[0] = 8'hB0;
    cmd_data[0] = 8'h07;
    cmd_valid[0] = 1'b1;
    tick();
    cmd_addr[0] = 8'h28;
    cmd_data[0] = 8'h10;
    for (int c = 1; c <= 80; c++) begin
      if (second >= 0 && c == second + 1) cmd_valid[0] = 1'b0;
      if (fm_cs_n[0] === 1'b0 && (seen.size() == 0 || seen[$] !== fm_din[0])) seen.push_back(fm_din[0]);
      if (fm_cs_n[0] === 1'b1 && fm_wr_n[0] !== 1'b1) gap_wr++;
      if (wr_done[0] === 1'b1) dones++;
      if (cmd_ready[0] === 1'b1 && cmd_valid[0] === 1'b1 && second < 0) second = c;
      tick();
    end
    checks++;
    if (second != 1 + 3 * 2 + 32) begin
      errors++;
      $display("FAIL b2b_second_accept: cycle %0d, expected %0d", second, 1 + 3 * 2 + 32);
    end
    checks++;
    if (seen.size() != 4 || seen[0] !== 8'hB0 || seen[1] !== 8'h07 || seen[2] !== 8'h28 || seen[3] !== 8'h10) begin
      errors++;
      $display("FAIL b2b_din_order: got %p, expected B0 07 28 10", seen);
    end
    checks++;
    if (gap_wr != 0 || dones != 2) begin
      errors++;
      $display("FAIL b2b_gap_done: wr_n low while deselected %0d times, wr_done %0d, expected 0 and 2", gap_wr, dones);
    end
  endtask

  task automatic test_cen_quarter();
    bus_t got;
    int wr_low = 0;
    int ready_at = -1;
    for (int i = 0; i < 1024; i++) cen_plan[i] = (i % 4 == 0);
    build_timeline(8'h40, 8'h7F, 1, 1, 1, 32);
    cmd_addr[0] = 8'h40;
    cmd_data[0] = 8'h7F;
    cmd_valid[0] = 1'b1;
    cen[0] = cen_plan[0];
    tick();
    cmd_valid[0] = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      cen[0] = cen_plan[k + 1];
      got = observe(0);
      if (fm_wr_n[0] === 1'b0) wr_low++;
      if (cmd_ready[0] === 1'b1 && ready_at < 0) ready_at = k + 1;
      checks++;
      if (got !== exp_q[k] || cmd_ready[0] !== exp_q[k].done) begin
        errors++;
        $display("FAIL cen4_wave cyc%0d: got %h rdy=%b, expected %h", k + 1, got, cmd_ready[0], exp_q[k]);
      end
      tick();
    end
    cen[0] = 1'b1;
    checks++;
    if (wr_low != 2 * 4 || ready_at != 1 + 4 * (6 + 32)) begin
      errors++;
      $display("FAIL cen4_stretch: wr_n low %0d cycles, ready at %0d, expected %0d and %0d",
               wr_low, ready_at, 2 * 4, 1 + 4 * (6 + 32));
    end
  endtask

  task automatic test_random_cen();
    bus_t got;
    logic [7:0] ra, rd;
    for (int it = 0; it < 6; it++) begin
      ra = 8'($urandom);
      rd = 8'($urandom);
      for (int i = 0; i < 1024; i++) cen_plan[i] = ($urandom_range(0, 3) != 0);
      build_timeline(ra, rd, 2, 3, 2, 0);
      cmd_addr[2] = ra;
      cmd_data[2] = rd;
      cmd_valid[2] = 1'b1;
      cen[2] = cen_plan[0];
      checks++;
      if (cmd_ready[2] !== 1'b1) begin
        errors++;
        $display("FAIL rand_accept it%0d: ready=%b expected 1", it, cmd_ready[2]);
      end
      tick();
      cmd_valid[2] = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
        cen[2] = cen_plan[k + 1];
        got = observe(2);
        checks++;
        if (got !== exp_q[k] || cmd_ready[2] !== exp_q[k].done) begin
          errors++;
          $display("FAIL rand_wave it%0d cyc%0d: got %h rdy=%b, expected %h", it, k + 1, got, cmd_ready[2], exp_q[k]);
        end
        tick();
      end
    end
  endtask

  task automatic test_busy_release();
    int bw_start = 1 + 6;
    int busy_len = 10;
    int done_at = -1;
    int err_cnt = 0;
    int bad = 0;
    cen[1] = 1'b1;
    cmd_addr[1] = 8'h30;
    cmd_data[1] = 8'($urandom);
    fm_dout[1] = 8'h80;
    cmd_valid[1] = 1'b1;
    tick();
    cmd_valid[1] = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      fm_dout[1] = {(c < bw_start + busy_len), 7'($urandom)};
      if (wr_done[1] === 1'b1 && done_at < 0) done_at = c;
      if (busy_err[1] === 1'b1) err_cnt++;
      if (c >= bw_start && c <= bw_start + busy_len && (fm_cs_n[1] !== 1'b1 || seq_busy[1] !== 1'b1)) bad++;
      tick();
    end
    checks++;
    if (done_at != bw_start + busy_len + 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL busy_release: wr_done at %0d, busy_err %0d, expected %0d and 0", done_at, err_cnt, bw_start + busy_len + 1);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_wait_bus: %0d cycles with cs active or not busy, expected 0", bad);
    end
  endtask

  task automatic test_busy_timeout();
    int bw_start = 1 + 6;
    int err_at = -1;
    int err_cnt = 0;
    int dones = 0;
    int rdy_at_err = 0;
    cen[1] = 1'b1;
    cmd_addr[1] = 8'h50;
    cmd_data[1] = 8'h1F;
    fm_dout[1] = 8'h80;
    cmd_valid[1] = 1'b1;
    tick();
    cmd_valid[1] = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      fm_dout[1] = {1'b1, 7'($urandom)};
      if (busy_err[1] === 1'b1) begin
        err_cnt++;
        if (err_at < 0) begin
          err_at = c;
          rdy_at_err = cmd_ready[1];
        end
      end
      if (wr_done[1] === 1'b1) dones++;
      tick();
    end
    fm_dout[1] = 8'h00;
    checks++;
    if (err_at != bw_start + 16 || err_cnt != 1 || dones != 0 || rdy_at_err != 1) begin
      errors++;
      $display("FAIL busy_timeout: err at %0d x%0d, wr_done %0d, ready %0d, expected %0d x1, 0, 1",
               err_at, err_cnt, dones, rdy_at_err, bw_start + 16);
    end
  endtask

  task automatic test_reset_mid_write();
    bus_t got;
    int dones = 0;
    cen[0] = 1'b1;
    cmd_addr[0] = 8'h60;
    cmd_data[0] = 8'h55;
    cmd_valid[0] = 1'b1;
    tick();
    cmd_valid[0] = 1'b0;
    tick();
    checks++;
    if (fm_wr_n[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre: wr_n=%b expected 0", fm_wr_n[0]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (fm_wr_n[0] !== 1'b1 || fm_cs_n[0] !== 1'b1 || cmd_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_bus: wr=%b cs=%b rdy=%b, expected 1 1 0", fm_wr_n[0], fm_cs_n[0], cmd_ready[0]);
    end
    rst = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (wr_done[0] === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done: wr_done %0d, expected 0", dones);
    end
    for (int i = 0; i < 1024; i++) cen_plan[i] = 1'b1;
    build_timeline(8'hA4, 8'h24, 1, 1, 1, 32);
    cmd_addr[0] = 8'hA4;
    cmd_data[0] = 8'h24;
    cmd_valid[0] = 1'b1;
    tick();
    cmd_valid[0] = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      got = observe(0);
      checks++;
      if (got !== exp_q[k] || cmd_ready[0] !== exp_q[k].done) begin
        errors++;
        $display("FAIL abort_recover cyc%0d: got %h rdy=%b, expected %h", k + 1, got, cmd_ready[0], exp_q[k]);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      cen[u] = 1'b1;
      cmd_valid[u] = 1'b0;
      cmd_addr[u] = 8'h00;
      cmd_data[u] = 8'h00;
      fm_dout[u] = 8'h00;
    end
    test_reset();
    test_single_write();
    test_back_to_back();
    test_cen_quarter();
    test_random_cen();
    test_busy_release();
    test_busy_timeout();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
